fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NUM_THREADS, default `NUM_THREADS (4), number of hardware threads.
REQ-002 Parameter THREAD_ID_WIDTH, default `THREAD_ID_WIDTH (2), thread index width.
REQ-003 Parameter PC_WIDTH, default 8, program counter width.
REQ-004 Parameter INSTR_WIDTH, default 16, instruction width.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  launch pulse: activate all threads at start_pc.
REQ-008 start_pc  in  PC_WIDTH  launch PC for every thread.
REQ-009 sched_valid  in  1  scheduler offers a thread this cycle.
REQ-010 sched_thread  in  THREAD_ID_WIDTH  thread chosen by the round-robin scheduler.
REQ-011 active_threads  out  NUM_THREADS  per-thread runnable mask, fed to the scheduler.
REQ-012 imem_req  out  1  instruction memory request.
REQ-013 imem_addr  out  PC_WIDTH  request address.
REQ-014 imem_ack  in  1  memory returns data this cycle.
REQ-015 imem_rdata  in  INSTR_WIDTH  returned instruction.
REQ-016 instr_valid  out  1  fetched instruction available to decode.
REQ-017 instr_ready  in  1  decode accepts the instruction.
REQ-018 instr  out  INSTR_WIDTH  fetched instruction.
REQ-019 instr_thread  out  THREAD_ID_WIDTH  owning thread of instr.
REQ-020 instr_pc  out  PC_WIDTH  PC of instr.
REQ-021 redirect_valid, redirect_thread, redirect_pc  in  1/THREAD_ID_WIDTH/PC_WIDTH  branch target update from execute.
REQ-022 halt_valid, halt_thread  in  1/THREAD_ID_WIDTH  thread finished; remove from mask.

Function
REQ-023 Block SHALL hold one PC_WIDTH PC register per thread and a 3-state FSM: IDLE, REQ, OUT.
REQ-024 IDLE: if sched_valid and active_threads[sched_thread], latch thread id, drive imem_addr = pc[thread], assert imem_req next cycle, enter REQ; otherwise stay IDLE.
REQ-025 REQ: imem_req and imem_addr SHALL stay stable until imem_ack; on imem_ack capture imem_rdata, thread, PC into output regs, enter OUT with instr_valid = 1 next cycle.
REQ-026 OUT: instr, instr_thread, instr_pc stable while instr_valid=1 and instr_ready=0; on instr_ready, pc[thread] <= pc[thread]+1, instr_valid <= 0, enter IDLE.
REQ-027 Minimum latency sched accept -> instr_valid: 2 cycles with imem_ack in first REQ cycle; throughput at most one instruction per 3 cycles.
REQ-028 PC increment SHALL wrap modulo 2^PC_WIDTH (max PC + 1 -> 0).
REQ-029 redirect_valid SHALL load pc[redirect_thread] <= redirect_pc in any state; redirect beats the REQ-026 increment for the same thread in the same cycle.
REQ-030 Redirect to the in-flight thread in REQ: squash flag set; on imem_ack data discarded, FSM -> IDLE, instr_valid stays 0.
REQ-031 Redirect to the in-flight thread in OUT: instr_valid drops next cycle, FSM -> IDLE, no increment (sole permitted valid withdrawal).
REQ-032 halt_valid SHALL clear active_threads[halt_thread] next cycle; in-flight fetch of that thread squashed per REQ-030/031; halt with redirect to same thread: bit cleared, PC still loaded.
REQ-033 start accepted only in IDLE: all PCs <= start_pc, active_threads <= all ones; start outside IDLE ignored; start with same-cycle halt: halt bit stays cleared.
REQ-034 sched_thread with inactive bit, or sched_valid outside IDLE, SHALL be ignored.

Reset
REQ-035 On reset: FSM IDLE, all PCs 0, active_threads 0, imem_req 0, imem_addr 0, instr_valid 0, instr/instr_thread/instr_pc 0, squash flag 0; reset overrides all other inputs including start.

Verification
REQ-036 reset, start with start_pc=0x10, sched thread 2, ack after 1 cycle, ready high -> imem_addr=0x10, instr_thread=2, instr_pc=0x10, pc[2]=0x11.
REQ-037 instr_ready held low 5 cycles -> instr/instr_pc/instr_thread unchanged, no new imem_req.
REQ-038 pc[1]=0xFF, fetch thread 1 -> instr_pc=0xFF, next fetch address 0x00.
REQ-039 redirect thread 0 to 0x40 in REQ while fetching thread 0 -> ack data dropped, instr_valid never 1, next fetch of 0 at 0x40.
REQ-040 halt thread 3 with sched of thread 3 pending -> active_threads=4'b0111, sched of 3 ignored, imem_req stays 0.
REQ-041 redirect thread 1 to 0x20 in the cycle instr_ready accepts thread 1 -> pc[1]=0x20, not incremented.

Source files
------------

// File: rtl/fetch_unit.sv
// Multithreaded instruction fetch: one PC per thread, one fetch in flight,
// IDLE -> REQ -> OUT sequencing with redirect/halt squashing.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef THREAD_ID_WIDTH
`define THREAD_ID_WIDTH 2
`endif

module fetch_unit #(
  parameter int NUM_THREADS     = `NUM_THREADS,
  parameter int THREAD_ID_WIDTH = `THREAD_ID_WIDTH,
  parameter int PC_WIDTH        = 8,
  parameter int INSTR_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [PC_WIDTH-1:0]        start_pc,
  input  logic                       sched_valid,
  input  logic [THREAD_ID_WIDTH-1:0] sched_thread,
  output logic [NUM_THREADS-1:0]     active_threads,
  output logic                       imem_req,
  output logic [PC_WIDTH-1:0]        imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTR_WIDTH-1:0]     imem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [INSTR_WIDTH-1:0]     instr,
  output logic [THREAD_ID_WIDTH-1:0] instr_thread,
  output logic [PC_WIDTH-1:0]        instr_pc,
  input  logic                       redirect_valid,
  input  logic [THREAD_ID_WIDTH-1:0] redirect_thread,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  input  logic                       halt_valid,
  input  logic [THREAD_ID_WIDTH-1:0] halt_thread,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                     state_q;
  logic [PC_WIDTH-1:0]        pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0]        pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]     active_q, active_d;
  logic [THREAD_ID_WIDTH-1:0] thread_q;
  logic                       imem_req_q;
  logic [PC_WIDTH-1:0]        imem_addr_q;
  logic                       instr_valid_q;
  logic [INSTR_WIDTH-1:0]     instr_q;
  logic [THREAD_ID_WIDTH-1:0] instr_thread_q;
  logic [PC_WIDTH-1:0]        instr_pc_q;
  logic                       squash_q;

  logic hit_redir, hit_halt, accept, retire, start_ok;

  // Handshakes: imem_req/imem_addr hold until the cycle imem_ack is seen; the
  // instruction transfers when instr_valid && instr_ready, and instr_valid only
  // drops without that transfer when its own thread is redirected or halted.
  assign hit_redir = redirect_valid && (redirect_thread == thread_q);
  assign hit_halt  = halt_valid && (halt_thread == thread_q);
  assign accept    = (state_q == S_IDLE) && sched_valid && active_q[sched_thread]
                     && !(halt_valid && (halt_thread == sched_thread));
  assign retire    = (state_q == S_OUT) && instr_ready;
  assign start_ok  = (state_q == S_IDLE) && start;

  // Later assignments win: redirect beats increment and start, halt beats start.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      pc_d[i] = start_ok ? start_pc : pc_q[i];
    end
    active_d = start_ok ? {NUM_THREADS{1'b1}} : active_q;
    if (retire) pc_d[thread_q] = pc_q[thread_q] + PC_WIDTH'(1);
    if (redirect_valid) pc_d[redirect_thread] = redirect_pc;
    if (halt_valid) active_d[halt_thread] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= '0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= pc_d[i];
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      thread_q       <= '0;
      imem_req_q     <= 1'b0;
      imem_addr_q    <= '0;
      instr_valid_q  <= 1'b0;
      instr_q        <= '0;
      instr_thread_q <= '0;
      instr_pc_q     <= '0;
      squash_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            thread_q    <= sched_thread;
            imem_addr_q <= pc_q[sched_thread];
            imem_req_q  <= 1'b1;
            // A same-cycle redirect makes the latched address stale.
            squash_q    <= redirect_valid && (redirect_thread == sched_thread);
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            squash_q   <= 1'b0;
            if (squash_q || hit_redir || hit_halt) begin
              state_q <= S_IDLE;
            end else begin
              instr_q        <= imem_rdata;
              instr_thread_q <= thread_q;
              instr_pc_q     <= imem_addr_q;
              instr_valid_q  <= 1'b1;
              state_q        <= S_OUT;
            end
          end else if (hit_redir || hit_halt) begin
            squash_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (instr_ready || hit_redir || hit_halt) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign active_threads = active_q;
  assign imem_req       = imem_req_q;
  assign imem_addr      = imem_addr_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_thread   = instr_thread_q;
  assign instr_pc       = instr_pc_q;
  assign dbg_state      = state_q;

endmodule
